// File: rtl/ram_block_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_block_mover_pkg
// Brief   : State encodings, mode constants and helpers for the block mover.
// Revision: 1.0 - initial release
// ============================================================================
package ram_block_mover_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic c_MODE_COPY = 1'b0;
  localparam logic c_MODE_FILL = 1'b1;

  // FILL never needs a read, so each word starts directly in WRITE.
  function automatic state_t f_word_state(input logic mode);
    return (mode == c_MODE_FILL) ? c_WRITE : c_READ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_block_mover_index_counter.sv
`default_nettype none
// ============================================================================
// Module  : ram_block_mover_index_counter
// Brief   : Word index counter with last-word flag for the block mover.
// Revision: 1.0 - initial release
// ============================================================================
module ram_block_mover_index_counter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] idx,
  output logic              idx_last
);

  logic [ADDR_W:0] r_idx;
  logic [ADDR_W:0] w_idx_next;

  // One extra bit so a 512-word transfer can reach idx+1 == 512.
  assign w_idx_next = r_idx + 1'b1;
  assign idx_last   = (w_idx_next == len);
  assign idx        = r_idx[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (inc) begin
      r_idx <= w_idx_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_block_mover.sv
`default_nettype none
// ============================================================================
// Module  : ram_block_mover
// Brief   : RAM initiator performing block COPY or FILL of up to 512 words.
// Revision: 1.0 - initial release
// ============================================================================
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  state_t            r_state;
  logic              r_mode;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_data;

  logic [ADDR_W-1:0] w_idx;
  logic              w_idx_last;
  logic              w_accept;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_accept = (r_state == c_IDLE) && start;

  ram_block_mover_index_counter #(
    .ADDR_W (ADDR_W)
  ) u_index_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_accept),
    .inc      (r_state == c_WRITE),
    .len      (r_len),
    .idx      (w_idx),
    .idx_last (w_idx_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_src   <= src;
            r_dst   <= dst;
            r_len   <= len;
            r_fill  <= fill_value;
            r_state <= (len == '0) ? c_DONE : f_word_state(mode);
          end
        end
        c_READ: begin
          r_data  <= mem_out;
          r_state <= c_WRITE;
        end
        c_WRITE: begin
          r_state <= w_idx_last ? c_DONE : f_word_state(r_mode);
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Addresses wrap naturally by truncation to ADDR_W bits.
  assign w_rd_addr = r_src + w_idx;
  assign w_wr_addr = r_dst + w_idx;

  always_comb begin
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    case (r_state)
      c_READ: begin
        mem_address = w_rd_addr;
      end
      c_WRITE: begin
        mem_address = w_wr_addr;
        mem_in      = (r_mode == c_MODE_FILL) ? r_fill : r_data;
        mem_load    = 1'b1;
      end
      default: begin
        mem_address = '0;
      end
    endcase
  end

  assign busy = (r_state == c_READ) || (r_state == c_WRITE);
  assign done = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_block_mover.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_block_mover
// Brief   : Self-checking bench: block mover driving a 512x16 RAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_block_mover;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  wr_t               sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  ram_block_mover #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .fill_value  (fill_value),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  // RAM512: combinational read, edge write; side port only used for preloading.
  assign mem_out = mem[mem_address];
  always @(posedge clk) begin
    if (mem_load)    mem[mem_address] <= mem_in;
    else if (pre_we) mem[pre_addr]    <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: each write the DUT issues is matched against the scoreboard.
  always @(negedge clk) begin
    if (mem_load) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {23'd0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {23'd0, mem_address}, {23'd0, e.addr});
        check("wr_data", {16'd0, mem_in}, {16'd0, e.data});
      end
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      check("done_with_busy", {31'd0, busy}, 32'd0);
    end
  end

  task automatic pre(input int a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    pre_we   = 1'b1;
    pre_addr = a[ADDR_W-1:0];
    pre_data = d;
    ref_mem[a & (DEPTH-1)] = d;
  endtask

  task automatic pre_end();
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Reference model: ascending word-by-word transfer over the shadow memory.
  task automatic model_xfer(input logic m, input int s, input int d, input int l,
                            input logic [DATA_W-1:0] f, input int limit);
    for (int i = 0; i < l && i < limit; i++) begin
      wr_t e;
      int  a;
      a      = (d + i) & (DEPTH-1);
      e.addr = a[ADDR_W-1:0];
      e.data = m ? f : ref_mem[(s + i) & (DEPTH-1)];
      ref_mem[a] = e.data;
      sb.push_back(e);
    end
  endtask

  task automatic check_range(input string tag, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (lo + i) & (DEPTH-1);
      check(tag, {16'd0, mem[a]}, {16'd0, ref_mem[a]});
    end
  endtask

  task automatic run_xfer(input logic m, input int s, input int d, input int l,
                          input logic [DATA_W-1:0] f, input bit glitch);
    int cycles;
    int exp_lat;
    model_xfer(m, s, d, l, f, DEPTH + 1);
    exp_lat = (l == 0) ? 1 : (m ? l + 1 : 2 * l + 1);
    @(posedge clk); #1;
    done_cnt   = 0;
    busy_cnt   = 0;
    start      = 1'b1;
    mode       = m;
    src        = s[ADDR_W-1:0];
    dst        = d[ADDR_W-1:0];
    len        = l[ADDR_W:0];
    fill_value = f;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (glitch && cycles == 2) begin
        start = 1'b1;
        dst   = dst + 9'd50;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", cycles, exp_lat);
    check("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, m ? l : 2 * l);
    sb.delete();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    src        = '0;
    dst        = '0;
    len        = '0;
    fill_value = '0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_load", {31'd0, mem_load}, 32'd0);
    check("rst_addr", {23'd0, mem_address}, 32'd0);
    check("rst_in", {16'd0, mem_in}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) pre(i, DATA_W'(i * 3 + 7));
    pre_end();

    // FILL dst=10 len=4
    run_xfer(1'b1, 0, 10, 4, 16'hBEEF, 1'b0);
    check("fill_m10", {16'd0, mem[10]}, 32'hBEEF);
    check("fill_m13", {16'd0, mem[13]}, 32'hBEEF);
    check_range("fill_range", 9, 6);

    // COPY of preloaded 1,2,3
    pre(0, 16'd1); pre(1, 16'd2); pre(2, 16'd3); pre_end();
    run_xfer(1'b0, 0, 100, 3, 16'h0, 1'b0);
    check("copy_m102", {16'd0, mem[102]}, 32'd3);
    check_range("copy_range", 99, 5);

    // Source wrap and destination wrap
    pre(510, 16'hA); pre(511, 16'hB); pre(0, 16'hC); pre(1, 16'hD); pre_end();
    run_xfer(1'b0, 510, 20, 4, 16'h0, 1'b0);
    check("wrap_m23", {16'd0, mem[23]}, 32'hD);
    check_range("wrap_copy", 19, 6);
    run_xfer(1'b1, 0, 511, 2, 16'h1234, 1'b0);
    check("wrap_m0", {16'd0, mem[0]}, 32'h1234);
    check_range("wrap_fill", 510, 4);

    // len=0 and start while busy
    run_xfer(1'b0, 5, 40, 0, 16'h0, 1'b0);
    run_xfer(1'b1, 0, 300, 3, 16'h7777, 1'b1);
    check_range("ignored_start", 298, 60);

    // Overlapping copy propagates
    pre(0, 16'd1); pre(1, 16'd2); pre(2, 16'd3); pre(3, 16'd4); pre_end();
    run_xfer(1'b0, 0, 1, 3, 16'h0, 1'b0);
    check("ovl_m3", {16'd0, mem[3]}, 32'd1);
    check_range("ovl_range", 0, 5);

    // Full-array FILL
    run_xfer(1'b1, 0, 77, 512, 16'hC0DE, 1'b0);
    check_range("full_fill", 0, DEPTH);

    // Reset during WRITE of word 2 of a 5-word FILL
    model_xfer(1'b1, 0, 200, 5, 16'h5A5A, 2);
    @(posedge clk); #1;
    done_cnt   = 0;
    start      = 1'b1;
    mode       = 1'b1;
    dst        = 9'd200;
    len        = 10'd5;
    fill_value = 16'h5A5A;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_load", {31'd0, mem_load}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_done", done_cnt, 0);
    check("abort_sb", sb.size(), 0);
    check_range("abort_range", 199, 7);
    sb.delete();

    run_xfer(1'b0, 200, 400, 5, 16'h0, 1'b0);
    check_range("post_reset", 399, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
